// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: reset/ROM constants and the IF/ID bundle.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0040_0000;
    localparam logic [31:0] TEXT_BASE_DEF  = 32'h0040_0000;
    localparam logic [31:0] IMEM_BYTES_DEF = 32'd512;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};

    // Redirect targets are word addresses; the low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: async reset, hold when en is low, bubble load on squash.
module if_id_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   squash,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= IF_ID_BUBBLE;
        end else if (en) begin
            q <= squash ? IF_ID_BUBBLE : d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and IF/ID, arbitrates EX branches, ID jumps and stalls.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] TEXT_BASE  = TEXT_BASE_DEF,
    parameter logic [31:0] IMEM_BYTES = IMEM_BYTES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        ex_branch_taken_i,
    input  logic [31:0] ex_branch_target_i,
    input  logic        id_jump_i,
    input  logic [31:0] id_jump_target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic        flush_id_ex_o,
    output logic        fetch_err_o
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_addr;
    logic        in_range;
    logic        hold;
    logic        take_jump;
    logic        squash;
    logic        err_set;
    logic        fetch_err;
    if_id_t      if_id_d;
    if_id_t      if_id_q;

    assign pc_plus4   = pc + 32'd4;
    assign fetch_addr = pc - TEXT_BASE;
    assign in_range   = fetch_addr < IMEM_BYTES;

    // A taken branch wins over stall: the stalled instruction is on the wrong path.
    assign hold      = stall_i & ~ex_branch_taken_i;
    assign take_jump = id_jump_i & if_id_q.valid & ~ex_branch_taken_i & ~stall_i;

    always_comb begin
        pc_next = pc_plus4;
        err_set = 1'b0;
        if (ex_branch_taken_i) begin
            pc_next = align_word(ex_branch_target_i);
            err_set = |ex_branch_target_i[1:0];
        end else if (hold) begin
            pc_next = pc;
        end else if (take_jump) begin
            pc_next = align_word(id_jump_target_i);
            err_set = |id_jump_target_i[1:0];
        end
        if (!hold && !in_range) begin
            err_set = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_err <= 1'b0;
        end else if (err_set) begin
            fetch_err <= 1'b1;
        end
    end

    // Redirects squash the sequential fetch; an out-of-range fetch never reaches decode.
    assign squash  = ex_branch_taken_i | take_jump | ~in_range;
    assign if_id_d = '{pc4: pc_plus4, instr: imem_instr_i, valid: 1'b1};

    if_id_reg u_if_id (
        .clk    (clk),
        .reset  (reset),
        .en     (~hold),
        .squash (squash),
        .d      (if_id_d),
        .q      (if_id_q)
    );

    assign imem_addr_o   = fetch_addr;
    assign pc_o          = pc;
    assign if_id_pc4_o   = if_id_q.pc4;
    assign if_id_instr_o = if_id_q.instr;
    assign if_id_valid_o = if_id_q.valid;
    assign flush_id_ex_o = ex_branch_taken_i | hold;
    assign fetch_err_o   = fetch_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run against a reference model.
module tb_fetch_stage;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        ex_branch_taken_i;
    logic [31:0] ex_branch_target_i;
    logic        id_jump_i;
    logic [31:0] id_jump_target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic [31:0] pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
    logic        flush_id_ex_o;
    logic        fetch_err_o;

    logic [31:0] rom [0:127];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_pc4;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_err;
    logic        m_loaded;
    logic [31:0] exp_q[$];

    fetch_stage dut (
        .clk                (clk),
        .reset              (reset),
        .stall_i            (stall_i),
        .ex_branch_taken_i  (ex_branch_taken_i),
        .ex_branch_target_i (ex_branch_target_i),
        .id_jump_i          (id_jump_i),
        .id_jump_target_i   (id_jump_target_i),
        .imem_addr_o        (imem_addr_o),
        .imem_instr_i       (imem_instr_i),
        .pc_o               (pc_o),
        .if_id_pc4_o        (if_id_pc4_o),
        .if_id_instr_o      (if_id_instr_o),
        .if_id_valid_o      (if_id_valid_o),
        .flush_id_ex_o      (flush_id_ex_o),
        .fetch_err_o        (fetch_err_o)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ROM returns a recognisable non-NOP pattern outside the text window
    assign imem_instr_i = (imem_addr_o < 32'd512) ? rom[imem_addr_o[8:2]] : 32'hBAD0_BAD0;

    // driver tasks
    task automatic drive(input logic b, input logic [31:0] btg, input logic s,
                         input logic j, input logic [31:0] jtg);
        ex_branch_taken_i  = b;
        ex_branch_target_i = btg;
        stall_i            = s;
        id_jump_i          = j;
        id_jump_target_i   = jtg;
    endtask

    task automatic model_reset();
        m_pc     = BASE;
        m_pc4    = 32'h0;
        m_instr  = 32'h0;
        m_valid  = 1'b0;
        m_err    = 1'b0;
        m_loaded = 1'b0;
    endtask

    // One clock edge of the fetch stage, straight from the priority rules.
    task automatic model_edge();
        logic [31:0] off;
        logic        oor;
        off      = m_pc - BASE;
        oor      = (off >= 32'd512);
        m_loaded = 1'b0;
        if (ex_branch_taken_i) begin
            if (ex_branch_target_i % 4 != 0 || oor) m_err = 1'b1;
            m_pc = ex_branch_target_i - (ex_branch_target_i % 4);
            m_pc4 = 0; m_instr = 0; m_valid = 0;
        end else if (stall_i) begin
            // everything holds
        end else if (id_jump_i && m_valid) begin
            if (id_jump_target_i % 4 != 0 || oor) m_err = 1'b1;
            m_pc = id_jump_target_i - (id_jump_target_i % 4);
            m_pc4 = 0; m_instr = 0; m_valid = 0;
        end else begin
            if (oor) begin
                m_err = 1'b1;
                m_pc4 = 0; m_instr = 0; m_valid = 0;
            end else begin
                m_pc4 = m_pc + 4; m_instr = rom[int'(off / 4)]; m_valid = 1; m_loaded = 1;
            end
            m_pc = m_pc + 4;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (pc_o !== BASE) begin n_fail++; $display("FAIL reset_pc_held: got %h want %h", pc_o, BASE); end
        reset = 1'b0;
        #1;
        n_checks++; if (imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr_o); end
        n_checks++; if (if_id_pc4_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h want 0", if_id_pc4_o); end
        n_checks++; if (if_id_instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", if_id_instr_o); end
        n_checks++; if (if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_id_valid_o); end
        n_checks++; if (fetch_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", fetch_err_o); end
    endtask

    task automatic test_sequential();
        drive(0, 0, 0, 0, 0);
        tick();
        n_checks++; if (pc_o !== 32'h0040_0004) begin n_fail++; $display("FAIL seq_pc1: got %h want 00400004", pc_o); end
        n_checks++; if (imem_addr_o !== 32'h4) begin n_fail++; $display("FAIL seq_addr1: got %h want 4", imem_addr_o); end
        n_checks++; if (if_id_pc4_o !== 32'h0040_0004) begin n_fail++; $display("FAIL seq_pc4_1: got %h want 00400004", if_id_pc4_o); end
        n_checks++; if (if_id_valid_o !== 1'b1) begin n_fail++; $display("FAIL seq_valid1: got %b want 1", if_id_valid_o); end
        n_checks++; if (if_id_instr_o !== rom[0]) begin n_fail++; $display("FAIL seq_instr1: got %h want %h", if_id_instr_o, rom[0]); end
        tick();
        n_checks++; if (pc_o !== 32'h0040_0008) begin n_fail++; $display("FAIL seq_pc2: got %h want 00400008", pc_o); end
        n_checks++; if (imem_addr_o !== 32'h8) begin n_fail++; $display("FAIL seq_addr2: got %h want 8", imem_addr_o); end
        n_checks++; if (if_id_pc4_o !== 32'h0040_0008) begin n_fail++; $display("FAIL seq_pc4_2: got %h want 00400008", if_id_pc4_o); end
        n_checks++; if (if_id_instr_o !== rom[1]) begin n_fail++; $display("FAIL seq_instr2: got %h want %h", if_id_instr_o, rom[1]); end
        tick();
        n_checks++; if (pc_o !== 32'h0040_000C) begin n_fail++; $display("FAIL seq_pc3: got %h want 0040000c", pc_o); end
    endtask

    task automatic test_stall();
        drive(0, 0, 0, 0, 0);
        tick();
        n_checks++; if (pc_o !== 32'h0040_0010) begin n_fail++; $display("FAIL stall_setup_pc: got %h want 00400010", pc_o); end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 0, 0);
            #1;
            n_checks++; if (flush_id_ex_o !== 1'b1) begin n_fail++; $display("FAIL stall_flush%0d: got %b want 1", i, flush_id_ex_o); end
            tick();
            n_checks++; if (pc_o !== 32'h0040_0010) begin n_fail++; $display("FAIL stall_pc%0d: got %h want 00400010", i, pc_o); end
            n_checks++; if (if_id_instr_o !== rom[3]) begin n_fail++; $display("FAIL stall_instr%0d: got %h want %h", i, if_id_instr_o, rom[3]); end
        end
        drive(0, 0, 0, 0, 0);
        #1;
        n_checks++; if (flush_id_ex_o !== 1'b0) begin n_fail++; $display("FAIL stall_release_flush: got %b want 0", flush_id_ex_o); end
        tick();
        n_checks++; if (pc_o !== 32'h0040_0014) begin n_fail++; $display("FAIL stall_resume_pc: got %h want 00400014", pc_o); end
        n_checks++; if (if_id_instr_o !== rom[4]) begin n_fail++; $display("FAIL stall_resume_instr: got %h want %h", if_id_instr_o, rom[4]); end
    endtask

    task automatic test_jump();
        drive(0, 0, 0, 1, 32'h0040_0040);
        #1;
        n_checks++; if (flush_id_ex_o !== 1'b0) begin n_fail++; $display("FAIL jump_flush: got %b want 0", flush_id_ex_o); end
        tick();
        n_checks++; if (pc_o !== 32'h0040_0040) begin n_fail++; $display("FAIL jump_pc: got %h want 00400040", pc_o); end
        n_checks++; if (if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL jump_bubble_valid: got %b want 0", if_id_valid_o); end
        n_checks++; if (if_id_instr_o !== 32'h0) begin n_fail++; $display("FAIL jump_bubble_instr: got %h want 0", if_id_instr_o); end
        drive(0, 0, 0, 0, 0);
        tick();
        n_checks++; if (if_id_instr_o !== rom[16]) begin n_fail++; $display("FAIL jump_target_instr: got %h want %h", if_id_instr_o, rom[16]); end
        n_checks++; if (if_id_pc4_o !== 32'h0040_0044) begin n_fail++; $display("FAIL jump_target_pc4: got %h want 00400044", if_id_pc4_o); end
    endtask

    task automatic test_branch_priority();
        drive(1, 32'h0040_0020, 1, 1, 32'h0040_0080);
        #1;
        n_checks++; if (flush_id_ex_o !== 1'b1) begin n_fail++; $display("FAIL branch_flush: got %b want 1", flush_id_ex_o); end
        tick();
        n_checks++; if (pc_o !== 32'h0040_0020) begin n_fail++; $display("FAIL branch_pc: got %h want 00400020", pc_o); end
        n_checks++; if (if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL branch_bubble: got %b want 0", if_id_valid_o); end
        n_checks++; if (fetch_err_o !== 1'b0) begin n_fail++; $display("FAIL branch_err: got %b want 0", fetch_err_o); end
        drive(0, 0, 0, 0, 0);
        tick();
        n_checks++; if (if_id_instr_o !== rom[8]) begin n_fail++; $display("FAIL branch_target_instr: got %h want %h", if_id_instr_o, rom[8]); end
    endtask

    task automatic test_random();
        logic b, s, j, exp_flush, new_load;
        logic [31:0] bt, jt, got;
        exp_q.delete();
        for (int n = 0; n < 400; n++) begin
            b  = ($urandom_range(0, 7) == 0);
            s  = ($urandom_range(0, 4) == 0);
            j  = ($urandom_range(0, 5) == 0);
            bt = BASE + 4 * $urandom_range(0, 127);
            jt = BASE + 4 * $urandom_range(0, 127);
            if (m_pc - BASE >= 32'h1F0) begin
                b  = 1'b1;
                bt = BASE;
            end
            drive(b, bt, s, j, jt);
            exp_flush = b | s;
            new_load  = ~(s & ~b);
            #1;
            n_checks++; if (flush_id_ex_o !== exp_flush) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %b want %b", n, flush_id_ex_o, exp_flush); end
            tick();
            if (m_loaded) exp_q.push_back(m_instr);
            n_checks++; if (pc_o !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, pc_o, m_pc); end
            n_checks++; if (imem_addr_o !== m_pc - BASE) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, imem_addr_o, m_pc - BASE); end
            n_checks++; if (if_id_pc4_o !== m_pc4) begin n_fail++; $display("FAIL rnd_pc4[%0d]: got %h want %h", n, if_id_pc4_o, m_pc4); end
            n_checks++; if (if_id_valid_o !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, if_id_valid_o, m_valid); end
            n_checks++; if (fetch_err_o !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", n, fetch_err_o, m_err); end
            if (new_load && if_id_valid_o === 1'b1) begin
                got = if_id_instr_o;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_stream[%0d]: got %h want none", n, got);
                end else if (got !== exp_q[0]) begin
                    n_fail++; $display("FAIL rnd_stream[%0d]: got %h want %h", n, got, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_stream_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_out_of_range();
        drive(1, 32'h0040_01F8, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        n_checks++; if (pc_o !== 32'h0040_0200) begin n_fail++; $display("FAIL oor_edge_pc: got %h want 00400200", pc_o); end
        n_checks++; if (if_id_instr_o !== rom[127]) begin n_fail++; $display("FAIL oor_last_instr: got %h want %h", if_id_instr_o, rom[127]); end
        n_checks++; if (fetch_err_o !== 1'b0) begin n_fail++; $display("FAIL oor_err_early: got %b want 0", fetch_err_o); end
        tick();
        n_checks++; if (fetch_err_o !== 1'b1) begin n_fail++; $display("FAIL oor_err_set: got %b want 1", fetch_err_o); end
        n_checks++; if (if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL oor_bubble_valid: got %b want 0", if_id_valid_o); end
        n_checks++; if (if_id_instr_o !== 32'h0) begin n_fail++; $display("FAIL oor_bubble_instr: got %h want 0", if_id_instr_o); end
        n_checks++; if (pc_o !== 32'h0040_0204) begin n_fail++; $display("FAIL oor_pc_adv: got %h want 00400204", pc_o); end
        drive(1, BASE, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        n_checks++; if (fetch_err_o !== 1'b1) begin n_fail++; $display("FAIL oor_err_sticky: got %b want 1", fetch_err_o); end
        n_checks++; if (if_id_instr_o !== rom[0]) begin n_fail++; $display("FAIL oor_recover_instr: got %h want %h", if_id_instr_o, rom[0]); end
    endtask

    task automatic test_misaligned_jump();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        tick();
        drive(0, 0, 0, 1, 32'h0040_0002);
        tick();
        n_checks++; if (pc_o !== BASE) begin n_fail++; $display("FAIL misalign_pc: got %h want 00400000", pc_o); end
        n_checks++; if (fetch_err_o !== 1'b1) begin n_fail++; $display("FAIL misalign_err: got %b want 1", fetch_err_o); end
        drive(0, 0, 0, 0, 0);
        tick();
        n_checks++; if (fetch_err_o !== 1'b1) begin n_fail++; $display("FAIL misalign_sticky: got %b want 1", fetch_err_o); end
    endtask

    task automatic test_reset_mid_redirect();
        drive(1, 32'h0040_0020, 1, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        n_checks++; if (pc_o !== BASE) begin n_fail++; $display("FAIL rstmid_pc: got %h want 00400000", pc_o); end
        n_checks++; if (if_id_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", if_id_valid_o); end
        n_checks++; if (if_id_pc4_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_pc4: got %h want 0", if_id_pc4_o); end
        n_checks++; if (fetch_err_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b want 0", fetch_err_o); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (pc_o !== BASE) begin n_fail++; $display("FAIL rstmid_hold_pc: got %h want 00400000", pc_o); end
        drive(0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        tick();
        n_checks++; if (pc_o !== 32'h0040_0004) begin n_fail++; $display("FAIL rstmid_restart_pc: got %h want 00400004", pc_o); end
        n_checks++; if (if_id_instr_o !== rom[0]) begin n_fail++; $display("FAIL rstmid_restart_instr: got %h want %h", if_id_instr_o, rom[0]); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = $urandom | 32'h1;
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_branch_priority();
        test_random();
        test_out_of_range();
        test_misaligned_jump();
        test_reset_mid_redirect();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
